// File: rtl/onewire_master_byte.sv
// onewire_master_byte: byte-level 1-Wire bus master (reset/presence, write byte, read byte, LSB first).
// Define ONEWIRE_OD_EN to add the odMode port and overdrive slot timing.
module onewire_master_byte #(
    parameter int CLKS_PER_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IO_i,
    output logic       IO_o,
    input  logic [1:0] cmd,
    input  logic       trig,
    input  logic [7:0] sentDat,
    output logic [7:0] receiveDat,
    output logic       presence,
    output logic       busy,
`ifdef ONEWIRE_OD_EN
    input  logic       odMode,
`endif
    output logic       done
);
    localparam int TW = $clog2(480 * CLKS_PER_US + 1);
    typedef logic [TW-1:0] tmr_t;
    typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, RST_HOLD, SLOT_LOW, SLOT_REL, FINISH} state_t;
    function automatic tmr_t us(input int std_us, input int od_us, input logic od);
        return tmr_t'((od ? od_us : std_us) * CLKS_PER_US);
    endfunction
    state_t     state_q, state_d;
    tmr_t       timer_q, timer_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d, rx_q, rx_d;
    logic       pres_q, pres_d;
    logic [1:0] sync_q;
    logic       od_q;
    tmr_t       rstl_end, msp, rsth_end, low_end, sample, slot_end;
`ifdef ONEWIRE_OD_EN
    always_ff @(posedge clk) od_q <= rst ? 1'b0 : (state_q == IDLE && trig) ? odMode : od_q;
`else
    assign od_q = 1'b0;
`endif
    // Phase timer counts up from 0; each phase ends on its last cycle so durations are exact.
    assign rstl_end = us(480, 70, od_q) - tmr_t'(1);
    assign msp      = us(70, 8, od_q);
    assign rsth_end = us(480, 48, od_q) - tmr_t'(1);
    assign low_end  = (tx_q[0] ? us(6, 1, od_q) : us(60, 8, od_q)) - tmr_t'(1);
    assign sample   = us(15, 2, od_q);
    assign slot_end = us(70, 11, od_q) - tmr_t'(1);
    assign IO_o       = !(state_q == RST_LOW || state_q == SLOT_LOW);
    assign busy       = state_q != IDLE && state_q != FINISH;
    assign done       = state_q == FINISH;
    assign receiveDat = rx_q;
    assign presence   = pres_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            pres_q  <= 1'b0;
            sync_q  <= 2'b11;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            pres_q  <= pres_d;
            sync_q  <= {sync_q[0], IO_i};
        end
    end
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + tmr_t'(1);
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        pres_d  = pres_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (trig) begin
                    bit_d   = '0;
                    tx_d    = cmd == 2'b10 ? 8'hFF : sentDat;
                    state_d = cmd == 2'b00 ? RST_LOW : cmd == 2'b11 ? FINISH : SLOT_LOW;
                end
            end
            RST_LOW: if (timer_q == rstl_end) begin
                state_d = RST_WAIT;
                timer_d = '0;
            end
            RST_WAIT: if (timer_q == msp) begin
                state_d = RST_HOLD;
                pres_d  = ~sync_q[1];
            end
            RST_HOLD: if (timer_q == rsth_end) state_d = FINISH;
            SLOT_LOW: if (timer_q == low_end) state_d = SLOT_REL;
            SLOT_REL: if (timer_q == slot_end) begin
                timer_d = '0;
                bit_d   = bit_q + 3'd1;
                tx_d    = tx_q >> 1;
                state_d = bit_q == 3'd7 ? FINISH : SLOT_LOW;
            end
            FINISH: begin
                state_d = IDLE;
                timer_d = '0;
            end
            default: state_d = IDLE;
        endcase
        // Every slot shifts the synchronised bus level in at the sample point, so writes return read-back.
        if ((state_q == SLOT_LOW || state_q == SLOT_REL) && timer_q == sample)
            rx_d = {sync_q[1], rx_q[7:1]};
    end
endmodule

// File: tb/tb_onewire_master_byte.sv
// tb_onewire_master_byte: directed bench with a segment-level bus model and a small 1-Wire slave.
module tb_onewire_master_byte;
    localparam int N = 4;
    logic clk = 0, rst = 1, trig = 0, od = 0, sl = 1;
    logic IO_i, IO_o, presence, busy, done;
    logic [1:0] cmd = 0;
    logic [7:0] sentDat = 0, receiveDat, sbyte = 0;
    logic [2:0] sidx = 0;
    int smode = 0;
    int nvec = 0, nerr = 0, lowrun = 0, cyc;
    bit run = 0;
    logic [2:0] exp_q[$];
    logic [2:0] e_cur;
    int pulses[$];
    logic [7:0] exp_rx = 0;
    logic exp_pres = 0;
    int lit_a5[8] = '{6, 60, 6, 60, 60, 6, 60, 6};
    assign IO_i = IO_o & sl;
    always #5 clk = ~clk;
    onewire_master_byte #(.CLKS_PER_US(N)) dut (
        .clk(clk), .rst(rst), .IO_i(IO_i), .IO_o(IO_o), .cmd(cmd), .trig(trig),
        .sentDat(sentDat), .receiveDat(receiveDat), .presence(presence), .busy(busy),
`ifdef ONEWIRE_OD_EN
        .odMode(od),
`endif
        .done(done)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Presence answer: low from 30us to 150us after the reset pulse is released.
    always begin
        @(posedge IO_o);
        if (smode == 1) begin
            repeat (30 * N) @(negedge clk);
            sl = 0;
            repeat (120 * N) @(negedge clk);
            sl = 1;
        end
    end
    // Read answer: hold the bus low to 30us for each 0 bit of sbyte.
    always begin
        @(negedge IO_o);
        if (smode == 2) begin
            if (!sbyte[sidx]) begin
                sl = 0;
                repeat (30 * N) @(negedge clk);
                sl = 1;
            end
            sidx = sidx + 3'd1;
        end
    end
    always begin
        @(posedge clk);
        #1;
        if (run) begin
            e_cur = exp_q.size() > 0 ? exp_q.pop_front() : 3'b100;
            chk("io/busy/done", {IO_o, busy, done}, e_cur);
            if (!IO_o) lowrun++;
            else if (lowrun > 0) begin
                pulses.push_back(lowrun);
                lowrun = 0;
            end
        end
    end
    task automatic push(input logic [2:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask
    task automatic model(input logic [1:0] c, input logic [7:0] d, input logic o);
        int w1, w0, slot, l;
        logic [7:0] b;
        w1 = o ? 1 : 6;
        w0 = o ? 8 : 60;
        slot = o ? 11 : 70;
        if (c == 2'b00) begin
            push(3'b010, (o ? 70 : 480) * N);
            push(3'b110, (o ? 48 : 480) * N);
            exp_pres = smode == 1 && !o;
        end else if (c != 2'b11) begin
            b = c == 2'b01 ? d : 8'hFF;
            for (int i = 0; i < 8; i++) begin
                l = b[i] ? w1 : w0;
                push(3'b010, l * N);
                push(3'b110, (slot - l) * N);
                exp_rx[i] = b[i] & (smode == 2 ? sbyte[i] : 1'b1);
            end
        end
        push(3'b101, 1);
    endtask
    task automatic start(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd = c;
        sentDat = d;
        trig = 1;
        pulses.delete();
        lowrun = 0;
        model(c, d, od);
    endtask
    task automatic finish_txn(input string name, output int n_cyc);
        n_cyc = -1;
        for (int i = 0; i < 1500 * N; i++) begin
            @(negedge clk);
            trig = 0;
            if (done) begin
                n_cyc = i;
                break;
            end
        end
        if (n_cyc < 0) exp_q.delete();
        chk({name, " done seen"}, n_cyc >= 0, 1);
        @(negedge clk);
        chk({name, " receiveDat"}, receiveDat, exp_rx);
        chk({name, " presence"}, presence, exp_pres);
        chk({name, " model drained"}, exp_q.size(), 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        chk("reset IO_o", IO_o, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset presence", presence, 0);
        chk("reset receiveDat", receiveDat, 8'h00);
        run = 1;
        smode = 1;
        start(2'b00, 8'h00);
        finish_txn("rst present", cyc);
        chk("rst present lit presence", presence, 1);
        chk("rst present lit low width", pulses[0], 480 * N);
        chk("rst present lit done time", cyc, 960 * N);
        smode = 0;
        start(2'b00, 8'h00);
        finish_txn("rst absent", cyc);
        chk("rst absent lit presence", presence, 0);
        chk("rst absent lit done time", cyc, 960 * N);
        start(2'b01, 8'hA5);
        finish_txn("write A5", cyc);
        chk("write A5 lit rx", receiveDat, 8'hA5);
        chk("write A5 lit pulse count", pulses.size(), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("write A5 lit pulse %0d", k), pulses[k], lit_a5[k] * N);
        chk("write A5 lit done time", cyc, 560 * N);
        smode = 2;
        sbyte = 8'h3C;
        sidx = 0;
        start(2'b10, 8'h00);
        finish_txn("read 3C", cyc);
        chk("read 3C lit rx", receiveDat, 8'h3C);
        for (int k = 0; k < 8; k++) chk($sformatf("read 3C lit pulse %0d", k), pulses[k], 6 * N);
        sbyte = 8'h96;
        sidx = 0;
        start(2'b01, 8'hF0);
        finish_txn("write F0 slave 96", cyc);
        chk("write F0 lit rx", receiveDat, 8'h90);
        smode = 0;
        start(2'b11, 8'h55);
        finish_txn("reserved", cyc);
        chk("reserved lit done time", cyc, 0);
        chk("reserved lit rx held", receiveDat, 8'h90);
        start(2'b01, 8'h0F);
        @(negedge clk);
        trig = 0;
        repeat (100 * N) @(negedge clk);
        cmd = 2'b00;
        trig = 1;
        @(negedge clk);
        trig = 0;
        repeat (200 * N) @(negedge clk);
        chk("abort lit IO_o before rst", IO_o, 0);
        chk("abort lit busy before rst", busy, 1);
        rst = 1;
        exp_q.delete();
        exp_rx = 0;
        exp_pres = 0;
        @(negedge clk);
        rst = 0;
        chk("abort lit IO_o after rst", IO_o, 1);
        chk("abort lit busy after rst", busy, 0);
        chk("abort lit rx after rst", receiveDat, 8'h00);
        repeat (20) @(negedge clk);
`ifdef ONEWIRE_OD_EN
        od = 1;
        start(2'b00, 8'h00);
        finish_txn("od rst", cyc);
        chk("od rst lit low width", pulses[0], 70 * N);
        chk("od rst lit done time", cyc, 118 * N);
        start(2'b01, 8'h01);
        finish_txn("od write 01", cyc);
        chk("od write lit pulse 0", pulses[0], 1 * N);
        for (int k = 1; k < 8; k++) chk($sformatf("od write lit pulse %0d", k), pulses[k], 8 * N);
        chk("od write lit done time", cyc, 88 * N);
        chk("od write lit rx", receiveDat, 8'h01);
        od = 0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
